// File: rtl/frame_packetizer.sv
// Groups an unthrottled word stream into fixed-length frames, buffers admitted
// frames in a FWFT FIFO and emits each one behind a sequence-number header.
module frame_packetizer #(
  parameter int DATA_WIDTH = 6,
  parameter int FRAME_LEN  = 4,
  parameter int FIFO_AW    = 4,
  parameter int DROP_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic                  up_valid,
  input  logic [DATA_WIDTH-1:0] up_data,
  input  logic                  down_ready,
  output logic                  down_valid,
  output logic [DATA_WIDTH-1:0] down_data,
  output logic                  down_sof,
  output logic                  down_eof,
  output logic [DROP_WIDTH-1:0] drop_cnt
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int IDXW  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);
  localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   FLEN_C   = CW'(FRAME_LEN);

  typedef enum logic {HDR = 1'b0, DATA = 1'b1} state_t;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [FIFO_AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [IDXW-1:0]       in_idx_q, in_idx_d;
  logic                  in_drop_q, in_drop_d;
  logic [DATA_WIDTH-1:0] seq_q, seq_d;
  logic [DROP_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  state_t                state_q, state_d;
  logic [IDXW-1:0]       dcnt_q, dcnt_d;

  logic [CW-1:0]         free;
  logic                  admit;
  logic                  frame_start;
  logic                  push;
  logic                  pop;
  logic                  nonempty;
  logic [DATA_WIDTH-1:0] head;

  // Admission looks only at the pre-edge count, so a pop in the same cycle is not credited.
  always_comb begin
    free        = DEPTH_C - count_q;
    admit       = (free >= FLEN_C);
    frame_start = up_valid && (in_idx_q == '0);
    nonempty    = (count_q != '0);
    head        = mem_q[rd_ptr_q];
    push        = 1'b0;
    if (up_valid) begin
      push = (in_idx_q == '0) ? admit : !in_drop_q;
    end
    push = push && (count_q != DEPTH_C);
    pop  = (state_q == DATA) && nonempty && down_ready;
  end

  always_comb begin
    in_idx_d   = in_idx_q;
    in_drop_d  = in_drop_q;
    drop_cnt_d = drop_cnt_q;
    if (up_valid) begin
      in_idx_d = (in_idx_q == LAST_IDX) ? '0 : in_idx_q + 1'b1;
    end
    if (frame_start) begin
      in_drop_d = !admit;
      if (!admit && (drop_cnt_q != {DROP_WIDTH{1'b1}})) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
    wr_ptr_d = wr_ptr_q + FIFO_AW'(push);
    rd_ptr_d = rd_ptr_q + FIFO_AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    seq_d   = seq_q;
    case (state_q)
      HDR: begin
        if (nonempty && down_ready) begin
          state_d = DATA;
          dcnt_d  = '0;
        end
      end
      DATA: begin
        if (pop) begin
          if (dcnt_q == LAST_IDX) begin
            dcnt_d  = '0;
            seq_d   = seq_q + 1'b1;
            state_d = HDR;
          end else begin
            dcnt_d = dcnt_q + 1'b1;
          end
        end
      end
      default: state_d = HDR;
    endcase
  end

  // Markers and data are qualified by valid so an idle port shows all zeros.
  always_comb begin
    down_valid = nonempty;
    down_sof   = nonempty && (state_q == HDR);
    down_eof   = nonempty && (state_q == DATA) && (dcnt_q == LAST_IDX);
    down_data  = '0;
    if (nonempty) begin
      down_data = (state_q == HDR) ? seq_q : head;
    end
    drop_cnt = drop_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= up_data;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      in_idx_q   <= '0;
      in_drop_q  <= 1'b0;
      seq_q      <= '0;
      drop_cnt_q <= '0;
      state_q    <= HDR;
      dcnt_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      in_idx_q   <= in_idx_d;
      in_drop_q  <= in_drop_d;
      seq_q      <= seq_d;
      drop_cnt_q <= drop_cnt_d;
      state_q    <= state_d;
      dcnt_q     <= dcnt_d;
    end
  end

endmodule

// File: tb/tb_frame_packetizer.sv
// Directed bench for frame_packetizer: hand-computed output words, drop counts
// and stall stability, checked with immediate assertions.
module tb_frame_packetizer;

  localparam int W = 6;

  logic         clk = 1'b0;
  logic         arst = 1'b0;
  logic         up_valid = 1'b0;
  logic [W-1:0] up_data = '0;
  logic         down_ready = 1'b0;
  logic         down_valid;
  logic [W-1:0] down_data;
  logic         down_sof;
  logic         down_eof;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] out_q[$];
  logic [7:0] cur_word;
  logic [7:0] prev_word = '0;
  bit         prev_stall = 1'b0;

  frame_packetizer #(
    .DATA_WIDTH(W), .FRAME_LEN(4), .FIFO_AW(4), .DROP_WIDTH(8)
  ) dut (
    .clk(clk), .arst(arst), .up_valid(up_valid), .up_data(up_data),
    .down_ready(down_ready), .down_valid(down_valid), .down_data(down_data),
    .down_sof(down_sof), .down_eof(down_eof), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  assign cur_word = {down_sof, down_eof, down_data};

  function automatic logic [7:0] w(input logic s, input logic e, input int d);
    logic [W-1:0] dd;
    dd = d[W-1:0];
    return {s, e, dd};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int d);
    up_valid = 1'b1;
    up_data  = d[W-1:0];
    tick();
    up_valid = 1'b0;
  endtask

  task automatic doReset();
    up_valid = 1'b0;
    arst = 1'b1;
    tick();
    tick();
    arst = 1'b0;
    tick();
    out_q.delete();
  endtask

  task automatic waitOut(input int n, input int budget);
    int c = 0;
    while (out_q.size() < n && c < budget) begin
      tick();
      c++;
    end
    checkOutput("wait_outputs", 32'(out_q.size()), 32'(n));
  endtask

  // Records every accepted word and checks that stalled words hold still.
  always @(negedge clk) begin
    if (arst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(down_valid), 32'd1);
        checkOutput("stall_hold", 32'(cur_word), 32'(prev_word));
      end
      if (down_valid && down_ready) out_q.push_back(cur_word);
      prev_stall = down_valid && !down_ready;
      prev_word  = cur_word;
    end
  end

  initial begin
    // Test 1: reset state, single frame, latency, next header
    arst = 1'b1;
    #1;
    checkOutput("rst_valid", 32'(down_valid), 32'd0);
    checkOutput("rst_word", 32'(cur_word), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    arst = 1'b0;
    tick();
    out_q.delete();
    down_ready = 1'b1;
    applyStimulus(17);
    checkOutput("t1_hdr_valid", 32'(down_valid), 32'd1);
    checkOutput("t1_hdr_word", 32'(cur_word), 32'(w(1, 0, 0)));
    applyStimulus(34);
    checkOutput("t1_first_data", 32'(cur_word), 32'(w(0, 0, 17)));
    applyStimulus(51);
    applyStimulus(5);
    waitOut(5, 40);
    checkOutput("t1_w0", 32'(out_q[0]), 32'(w(1, 0, 0)));
    checkOutput("t1_w1", 32'(out_q[1]), 32'(w(0, 0, 17)));
    checkOutput("t1_w2", 32'(out_q[2]), 32'(w(0, 0, 34)));
    checkOutput("t1_w3", 32'(out_q[3]), 32'(w(0, 0, 51)));
    checkOutput("t1_w4", 32'(out_q[4]), 32'(w(0, 1, 5)));
    for (int k = 1; k <= 4; k++) applyStimulus(k);
    waitOut(10, 40);
    checkOutput("t1_next_hdr", 32'(out_q[5]), 32'(w(1, 0, 1)));
    checkOutput("t1_drop", 32'(drop_cnt), 32'd0);

    // Test 2: five frames while stalled, fifth dropped
    doReset();
    down_ready = 1'b0;
    for (int k = 1; k <= 20; k++) applyStimulus(k);
    tick();
    checkOutput("t2_drop", 32'(drop_cnt), 32'd1);
    down_ready = 1'b1;
    waitOut(20, 60);
    for (int f = 0; f < 4; f++) begin
      checkOutput("t2_hdr", 32'(out_q[f*5]), 32'(w(1, 0, f)));
      for (int k = 0; k < 4; k++)
        checkOutput("t2_data", 32'(out_q[f*5+k+1]), 32'(w(0, k == 3, f*4+k+1)));
    end
    repeat (10) tick();
    checkOutput("t2_no_extra", 32'(out_q.size()), 32'd20);

    // Test 3: ready toggling during one frame
    doReset();
    for (int i = 0; i < 30; i++) begin
      case (i % 6)
        0, 3, 5: down_ready = 1'b1;
        default: down_ready = 1'b0;
      endcase
      if (i < 4) begin
        up_valid = 1'b1;
        up_data  = 6'(40 + i);
      end else begin
        up_valid = 1'b0;
      end
      tick();
    end
    up_valid = 1'b0;
    down_ready = 1'b1;
    waitOut(5, 20);
    checkOutput("t3_w0", 32'(out_q[0]), 32'(w(1, 0, 0)));
    for (int k = 0; k < 4; k++)
      checkOutput("t3_data", 32'(out_q[k+1]), 32'(w(0, k == 3, 40+k)));
    checkOutput("t3_size", 32'(out_q.size()), 32'd5);

    // Test 4: admission boundary at free=3 then free=4
    doReset();
    down_ready = 1'b0;
    for (int k = 1; k <= 16; k++) applyStimulus(k);
    down_ready = 1'b1;
    repeat (4) tick();
    down_ready = 1'b0;
    checkOutput("t4_read4", 32'(out_q.size()), 32'd4);
    for (int k = 21; k <= 24; k++) applyStimulus(k);
    checkOutput("t4_drop1", 32'(drop_cnt), 32'd1);
    down_ready = 1'b1;
    tick();
    down_ready = 1'b0;
    for (int k = 31; k <= 34; k++) applyStimulus(k);
    checkOutput("t4_drop_same", 32'(drop_cnt), 32'd1);
    down_ready = 1'b1;
    waitOut(25, 60);
    for (int f = 0; f < 4; f++) begin
      checkOutput("t4_hdr", 32'(out_q[f*5]), 32'(w(1, 0, f)));
      for (int k = 0; k < 4; k++)
        checkOutput("t4_data", 32'(out_q[f*5+k+1]), 32'(w(0, k == 3, f*4+k+1)));
    end
    checkOutput("t4_hdr_new", 32'(out_q[20]), 32'(w(1, 0, 4)));
    for (int k = 0; k < 4; k++)
      checkOutput("t4_data_new", 32'(out_q[21+k]), 32'(w(0, k == 3, 31+k)));

    // Test 5: reset in the middle of a frame
    doReset();
    down_ready = 1'b1;
    applyStimulus(50);
    applyStimulus(51);
    checkOutput("t5_pre_valid", 32'(down_valid), 32'd1);
    #2;
    arst = 1'b1;
    #1;
    checkOutput("t5_rst_valid", 32'(down_valid), 32'd0);
    checkOutput("t5_rst_word", 32'(cur_word), 32'd0);
    checkOutput("t5_rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    arst = 1'b0;
    tick();
    out_q.delete();
    for (int k = 60; k <= 63; k++) applyStimulus(k);
    waitOut(5, 40);
    checkOutput("t5_hdr", 32'(out_q[0]), 32'(w(1, 0, 0)));
    for (int k = 0; k < 4; k++)
      checkOutput("t5_data", 32'(out_q[k+1]), 32'(w(0, k == 3, 60+k)));

    // Test 6a: 65 frames, sequence wraps after 63
    doReset();
    down_ready = 1'b1;
    for (int f = 0; f < 65; f++) begin
      for (int k = 0; k < 4; k++) applyStimulus((f*4+k) % 64);
      tick();
    end
    waitOut(325, 100);
    for (int f = 0; f < 65; f++)
      checkOutput("t6_hdr", 32'(out_q[f*5]), 32'(w(1, 0, f % 64)));
    checkOutput("t6_last", 32'(out_q[324]), 32'(w(0, 1, (64*4+3) % 64)));
    checkOutput("t6_drop", 32'(drop_cnt), 32'd0);

    // Test 6b: drop counter saturation
    doReset();
    down_ready = 1'b0;
    for (int f = 0; f < 258; f++)
      for (int k = 0; k < 4; k++) applyStimulus(k);
    checkOutput("t6_drop254", 32'(drop_cnt), 32'd254);
    applyStimulus(0);
    checkOutput("t6_drop255", 32'(drop_cnt), 32'd255);
    for (int k = 0; k < 23; k++) applyStimulus(k);
    checkOutput("t6_drop_sat", 32'(drop_cnt), 32'd255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
